// File: rtl/im_boot_loader.sv
// Boot-time loader: streams 32-bit instruction words into a byte-wide instruction
// memory (big-endian, one byte per cycle), then releases the CPU and hands it the address port.
module im_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    WR0       = 3'd2,
    WR1       = 3'd3,
    WR2       = 3'd4,
    WR3       = 3'd5,
    RUN       = 3'd6,
    ERR       = 3'd7
  } state_t;

  localparam logic [ADDR_W-2:0] MAX_CNT    = (ADDR_W-1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              last;
  logic [ADDR_W-2:0] wl_inc;

  assign wl_inc = words_loaded + {{(ADDR_W-2){1'b0}}, 1'b1};

  // Load sequencer: start is honoured only between words (IDLE, RUN, ERR)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      ptr          <= '0;
      word         <= 32'h0000_0000;
      last         <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state        <= WAIT_WORD;
            ptr          <= '0;
            words_loaded <= '0;
          end else begin
            state <= state;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            word  <= in_data;
            last  <= in_last;
            state <= WR0;
          end else begin
            state <= WAIT_WORD;
          end
        end
        WR0: state <= WR1;
        WR1: state <= WR2;
        WR2: state <= WR3;
        WR3: begin
          ptr          <= ptr + WORD_BYTES;
          words_loaded <= wl_inc;
          if (last) begin
            state <= RUN;
          end else if (wl_inc == MAX_CNT) begin
            state <= ERR;
          end else begin
            state <= WAIT_WORD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of handshake/status plus the address/data mux for the memory port
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_run   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_addr  = ptr;
    mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        mem_addr = ptr;
      end
      WAIT_WORD: begin
        in_ready = 1'b1;
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = word[31:24];
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_addr  = ptr + ADDR_W'(1);
        mem_wdata = word[23:16];
      end
      WR2: begin
        mem_we    = 1'b1;
        mem_addr  = ptr + ADDR_W'(2);
        mem_wdata = word[15:8];
      end
      WR3: begin
        mem_we    = 1'b1;
        mem_addr  = ptr + ADDR_W'(3);
        mem_wdata = word[7:0];
      end
      RUN: begin
        cpu_run  = 1'b1;
        done     = 1'b1;
        mem_addr = pc;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        mem_addr = ptr;
      end
    endcase
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed testbench for im_boot_loader; inputs change and outputs are sampled on the falling edge.
module tb_im_boot_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  pc = 8'h00;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        cpu_run;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          handshakes = 0;

  im_boot_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_run(cpu_run), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory and handshake counter
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (in_valid && in_ready) handshakes <= handshakes + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_we"},    {31'h0, mem_we},   32'h0);
    check({tag, "_run"},   {31'h0, cpu_run},  32'h0);
    check({tag, "_done"},  {31'h0, done},     32'h0);
    check({tag, "_err"},   {31'h0, err},      32'h0);
  endtask

  task automatic check_write(input string tag, input logic [7:0] addr, input logic [7:0] data);
    check({tag, "_we"},    {31'h0, mem_we}, 32'h1);
    check({tag, "_addr"},  {24'h0, mem_addr}, {24'h0, addr});
    check({tag, "_wdata"}, {24'h0, mem_wdata}, {24'h0, data});
  endtask

  task automatic do_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Streams n words base+i back-to-back; in_last on index last_at (-1 for none)
  task automatic send_stream(input int n, input int last_at, input logic [31:0] base);
    int idx;
    idx = 0;
    for (int c = 0; c < 2000; c++) begin
      if (in_ready && idx < n) begin
        in_valid = 1'b1;
        in_data  = base + 32'(idx);
        in_last  = (idx == last_at);
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (done || err) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [31:0] words3 [0:2];
  int          idx3;
  bit          tog;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    words3[0] = 32'h1122_3344;
    words3[1] = 32'hAABB_CCDD;
    words3[2] = 32'h0102_0304;

    // Reset and idle
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check_quiet_outputs("idle");
    check("idle_addr", {24'h0, mem_addr}, 32'h0);

    // Single word, in_valid held high
    do_start;
    check("t1_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_data = 32'h2008_0005; in_last = 1'b1;
    @(negedge clk); check_write("t1_b0", 8'h00, 8'h20);
    @(negedge clk); check_write("t1_b1", 8'h01, 8'h08);
    @(negedge clk); check_write("t1_b2", 8'h02, 8'h00);
    @(negedge clk); check_write("t1_b3", 8'h03, 8'h05);
    @(negedge clk);
    check("t1_run",  {31'h0, cpu_run}, 32'h1);
    check("t1_done", {31'h0, done}, 32'h1);
    check("t1_wl",   {25'h0, words_loaded}, 32'h1);
    in_valid = 1'b0; in_last = 1'b0;
    pc = 8'h10; #1;
    check("t1_pc_pass", {24'h0, mem_addr}, 32'h10);
    check("t1_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h2008_0005);

    // Three words, in_valid toggling every other cycle
    do_start;
    handshakes = 0;
    idx3 = 0; tog = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tog = ~tog;
      if (tog && idx3 < 3) begin
        in_valid = 1'b1; in_data = words3[idx3]; in_last = (idx3 == 2);
        if (in_ready) idx3++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (done) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("t2_done", {31'h0, done}, 32'h1);
    check("t2_wl", {25'h0, words_loaded}, 32'h3);
    check("t2_hs", 32'(handshakes), 32'h3);
    check("t2_w0", {mem[0], mem[1], mem[2], mem[3]},   32'h1122_3344);
    check("t2_w1", {mem[4], mem[5], mem[6], mem[7]},   32'hAABB_CCDD);
    check("t2_w2", {mem[8], mem[9], mem[10], mem[11]}, 32'h0102_0304);

    // Overflow: 64 words without in_last
    do_start;
    send_stream(64, -1, 32'hC0DE_0000);
    check("t3_err",  {31'h0, err}, 32'h1);
    check("t3_run",  {31'h0, cpu_run}, 32'h0);
    check("t3_done", {31'h0, done}, 32'h0);
    check("t3_wl",   {25'h0, words_loaded}, 32'd64);
    check("t3_ptr",  {24'h0, mem_addr}, 32'h0);
    check("t3_w63",  {mem[252], mem[253], mem[254], mem[255]}, 32'hC0DE_003F);
    check("t3_w1",   {mem[4], mem[5], mem[6], mem[7]}, 32'hC0DE_0001);

    // 64 words with in_last on the last one
    do_start;
    check("t4_err_drop", {31'h0, err}, 32'h0);
    send_stream(64, 63, 32'h5A00_0000);
    check("t4_done", {31'h0, done}, 32'h1);
    check("t4_err",  {31'h0, err}, 32'h0);
    check("t4_wl",   {25'h0, words_loaded}, 32'd64);
    check("t4_w63",  {mem[252], mem[253], mem[254], mem[255]}, 32'h5A00_003F);

    // Restart from RUN
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t5_run",   {31'h0, cpu_run}, 32'h0);
    check("t5_done",  {31'h0, done}, 32'h0);
    check("t5_ready", {31'h0, in_ready}, 32'h1);
    check("t5_wl",    {25'h0, words_loaded}, 32'h0);

    // start during WR1 is ignored
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check_write("t6_b0", 8'h00, 8'hDE);
    @(negedge clk); check_write("t6_b1", 8'h01, 8'hAD);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_write("t6_b2", 8'h02, 8'hBE);
    @(negedge clk); check_write("t6_b3", 8'h03, 8'hEF);
    @(negedge clk);
    check("t6_done", {31'h0, done}, 32'h1);
    check("t6_wl", {25'h0, words_loaded}, 32'h1);

    // Asynchronous reset during WR2 of word 2
    do_start;
    in_valid = 1'b1; in_data = 32'h0101_0101; in_last = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0A0B_0C0D;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_write("t7_pre", 8'h06, 8'h0C);
    #2 rstn = 1'b0; #1;
    check_quiet_outputs("t7_rst");
    check("t7_addr",  {24'h0, mem_addr}, 32'h0);
    check("t7_wdata", {24'h0, mem_wdata}, 32'h0);
    check("t7_wl",    {25'h0, words_loaded}, 32'h0);
    @(negedge clk) rstn = 1'b1;
    check("t7_keep", {24'h0, mem[5]}, 32'h0B);

    // start together with in_valid in IDLE: word is not consumed on that edge
    in_valid = 1'b1; in_data = 32'h5566_7788; in_last = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t8_ready", {31'h0, in_ready}, 32'h1);
    check("t8_we",    {31'h0, mem_we}, 32'h0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    check_write("t8_b0", 8'h00, 8'h55);
    repeat (4) @(negedge clk);
    check("t8_done", {31'h0, done}, 32'h1);
    check("t8_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h5566_7788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Boot-time controller for the byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one big-endian, one byte per cycle, into the instruction memory byte write port. MSB byte goes to the lowest address.
- Holds the CPU stopped while loading, then hands the memory address port over to the CPU PC.
- Sits between the host/testbench stream, the CPU fetch path and the instruction memory.

Parameters:
- ADDR_W, 8: byte address width; equals PC width.
- MAX_WORDS, 64: capacity in words; MAX_WORDS*4 must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin or restart a load.
- in_valid  input  1  stream word valid.
- in_data  input  32  stream instruction word.
- in_last  input  1  marks the final word of the program; qualified by the handshake.
- in_ready  output  1  loader can accept a word.
- pc  input  ADDR_W  CPU fetch byte address.
- mem_addr  output  ADDR_W  instruction memory byte address.
- mem_wdata  output  8  byte to write.
- mem_we  output  1  byte write enable.
- cpu_run  output  1  CPU may execute; 0 holds the CPU.
- done  output  1  load completed successfully.
- err  output  1  overflow: MAX_WORDS words accepted without in_last.
- words_loaded  output  ADDR_W-1  count of words fully written.

Behaviour:
- States: IDLE, WAIT_WORD, WR0, WR1, WR2, WR3, RUN, ERR.
- State, ptr (ADDR_W), word register, last flag and words_loaded are registered.
- in_ready, mem_we, cpu_run, done and err are decoded from the registered state (Moore); mem_addr and mem_wdata are combinational from state, ptr, the word register and pc.
- Reset (rstn=0, asynchronous):
  - state=IDLE, ptr=0, words_loaded=0, word register=0.
  - Outputs: in_ready=0, mem_we=0, cpu_run=0, done=0, err=0, mem_addr=0, mem_wdata=0.
  - Reset mid-load aborts immediately. Bytes already written stay in memory and are not cleared.
- IDLE:
  - start=1 -> WAIT_WORD; ptr=0, words_loaded=0.
  - in_valid is ignored in IDLE.
- WAIT_WORD:
  - in_ready=1.
  - in_valid=1 -> latch in_data and in_last, go to WR0.
  - in_valid=0 -> stay; no timeout.
- WR0..WR3:
  - mem_we=1, in_ready=0.
  - mem_addr = ptr+0, +1, +2, +3 respectively (ADDR_W-bit wrap).
  - mem_wdata = word[31:24], [23:16], [15:8], [7:0] respectively.
  - WR0->WR1->WR2->WR3 unconditionally.
- Leaving WR3 (ptr+=4 and words_loaded+=1 in every case):
  - Last flag set -> RUN.
  - Else new words_loaded == MAX_WORDS -> ERR.
  - Else -> WAIT_WORD.
- Timing: word accepted on edge N; bytes written in cycles N+1..N+4; in_ready high again in cycle N+5. Peak throughput is 1 word per 5 cycles.
- RUN:
  - cpu_run=1, done=1, mem_we=0, mem_addr=pc (combinational pass-through, zero latency).
  - cpu_run rises in the cycle after WR3 of the last word.
- ERR:
  - err=1, cpu_run=0, mem_we=0, mem_addr=ptr.
  - Exited only by start or reset.
- In IDLE and WAIT_WORD: mem_addr=ptr, mem_wdata=0.
- Restart:
  - start=1 in RUN or ERR -> WAIT_WORD; ptr=0, words_loaded=0.
  - cpu_run, done and err drop in the next cycle.
  - start in WAIT_WORD or WR0..WR3 is ignored (no restart mid-word).
- Simultaneous events:
  - start and in_valid in IDLE: only start acts; the word is not consumed (in_ready=0).
  - in_last=1 on the MAX_WORDS-th word -> RUN, not ERR.
- words_loaded saturates by construction at MAX_WORDS and holds its value in RUN/ERR until restart.

Test Plan:
- Reset, then idle 5 cycles -> cpu_run=0, done=0, err=0, in_ready=0, mem_we=0.
- start; send 0x20080005 with in_last=1 and in_valid held high:
  - writes 0x20@0, 0x08@1, 0x00@2, 0x05@3 on consecutive cycles.
  - cpu_run=1 one cycle later; words_loaded=1.
  - pc=0x10 -> mem_addr=0x10.
- start; 3 words 0x11223344, 0xAABBCCDD, 0x01020304, last on the third, in_valid toggling every other cycle:
  - bytes land at 0..11 in big-endian order.
  - no word is accepted while in_ready=0.
  - words_loaded=3; done=1.
- MAX_WORDS=64, 64 words with no in_last -> err=1, cpu_run=0, words_loaded=64, ptr=0 (wrapped at 256).
- Repeat with in_last on word 64 -> done=1, err=0.
- Assert rstn=0 during WR2 of word 2 -> all outputs reset asynchronously.
- After release plus start, the new load begins at address 0.
- start in RUN -> cpu_run=0 next cycle and in_ready=1.
- start pulse during WR1 -> ignored; the word completes normally.
